// File: rtl/rv_mem_arbiter_if.sv
// Bus bundle between the fetch/load-store requesters, the arbiter and the shared memory port.
// slave = arbiter view, master = requester/memory environment view.
interface rv_mem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic            if_req_i;
  logic [AW-1:0]   if_addr_i;
  logic            if_gnt_o;
  logic            if_rvalid_o;
  logic [DW-1:0]   if_rdata_o;

  logic            ls_req_i;
  logic            ls_we_i;
  logic [AW-1:0]   ls_addr_i;
  logic [DW-1:0]   ls_wdata_i;
  logic [DW/8-1:0] ls_be_i;
  logic            ls_gnt_o;
  logic            ls_rvalid_o;
  logic [DW-1:0]   ls_rdata_o;

  logic            mem_req_o;
  logic            mem_we_o;
  logic [AW-1:0]   mem_addr_o;
  logic [DW-1:0]   mem_wdata_o;
  logic [DW/8-1:0] mem_be_o;
  logic            mem_gnt_i;
  logic            mem_rvalid_i;
  logic [DW-1:0]   mem_rdata_i;

  modport slave (
    input  if_req_i, if_addr_i,
    output if_gnt_o, if_rvalid_o, if_rdata_o,
    input  ls_req_i, ls_we_i, ls_addr_i, ls_wdata_i, ls_be_i,
    output ls_gnt_o, ls_rvalid_o, ls_rdata_o,
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o,
    input  mem_gnt_i, mem_rvalid_i, mem_rdata_i
  );

  modport master (
    output if_req_i, if_addr_i,
    input  if_gnt_o, if_rvalid_o, if_rdata_o,
    output ls_req_i, ls_we_i, ls_addr_i, ls_wdata_i, ls_be_i,
    input  ls_gnt_o, ls_rvalid_o, ls_rdata_o,
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o,
    output mem_gnt_i, mem_rvalid_i, mem_rdata_i
  );
endinterface

// File: rtl/rv_mem_arbiter.sv
// Fetch / load-store arbiter onto one memory port, one transaction outstanding, LSU priority with IF anti-starvation.
// Latency: req->mem_req 1 cycle; stalls in ISSUE until mem_gnt_i and in WAIT until mem_rvalid_i (>=3 cycles/txn).
module rv_mem_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int STARVE_MAX = 4
) (
  input logic             sclk_i,
  input logic             srst_i,
  rv_mem_arbiter_if.slave bus
);
  localparam int BW = DW / 8;
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  typedef enum logic {OWN_IF, OWN_LS} owner_t;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [BW-1:0] be;
  } req_t;

  state_t        state_q, state_d;
  owner_t        owner_q, owner_d;
  req_t          req_q, req_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          any_req;
  logic          ls_wins;

  always_ff @(posedge sclk_i or posedge srst_i) begin
    if (srst_i) begin
      state_q  <= IDLE;
      owner_q  <= OWN_IF;
      req_q    <= '0;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      req_q    <= req_d;
      starve_q <= starve_d;
    end
  end

  assign any_req = bus.if_req_i | bus.ls_req_i;
  // LSU keeps priority until IF has lost STARVE_MAX arbitrations in a row
  assign ls_wins = (bus.ls_req_i && (starve_q < SMAX)) || !bus.if_req_i;

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    req_d    = req_q;
    starve_d = starve_q;

    bus.mem_req_o   = 1'b0;
    bus.mem_we_o    = 1'b0;
    bus.mem_addr_o  = '0;
    bus.mem_wdata_o = '0;
    bus.mem_be_o    = '0;
    bus.if_gnt_o    = 1'b0;
    bus.if_rvalid_o = 1'b0;
    bus.if_rdata_o  = '0;
    bus.ls_gnt_o    = 1'b0;
    bus.ls_rvalid_o = 1'b0;
    bus.ls_rdata_o  = '0;

    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d = ISSUE;
          if (ls_wins) begin
            owner_d = OWN_LS;
            req_d   = '{we: bus.ls_we_i, addr: bus.ls_addr_i,
                        wdata: bus.ls_wdata_i, be: bus.ls_be_i};
            if (bus.if_req_i && (starve_q != SMAX)) starve_d = starve_q + 1'b1;
          end else begin
            owner_d  = OWN_IF;
            req_d    = '{we: 1'b0, addr: bus.if_addr_i, wdata: '0, be: '1};
            starve_d = '0;
          end
        end
      end
      ISSUE: begin
        bus.mem_req_o   = 1'b1;
        bus.mem_we_o    = req_q.we;
        bus.mem_addr_o  = req_q.addr;
        bus.mem_wdata_o = req_q.wdata;
        bus.mem_be_o    = req_q.be;
        if (bus.mem_gnt_i) begin
          bus.if_gnt_o = (owner_q == OWN_IF);
          bus.ls_gnt_o = (owner_q == OWN_LS);
          state_d      = WAIT;
        end
      end
      WAIT: begin
        if (bus.mem_rvalid_i) begin
          if (owner_q == OWN_IF) begin
            bus.if_rvalid_o = 1'b1;
            bus.if_rdata_o  = bus.mem_rdata_i;
          end else begin
            bus.ls_rvalid_o = 1'b1;
            bus.ls_rdata_o  = bus.mem_rdata_i;
          end
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: doc/rv_mem_arbiter.md
RV_MEM_ARBITER -- requirements
Module: rv_mem_arbiter

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- AW, 32, address width.
- DW, 32, data width.
- STARVE_MAX, 4, LSU wins in a row before IF is forced.

REQ-002 The block SHALL have these ports (name  direction  width  meaning):
- sclk_i  in  1  clock; all state updates on rising edge.
- srst_i  in  1  asynchronous, active-high reset.
- if_req_i  in  1  instruction-fetch read request.
- if_addr_i  in  AW  fetch address.
- if_gnt_o  out  1  fetch request accepted.
- if_rvalid_o  out  1  fetch data valid.
- if_rdata_o  out  DW  fetch data.
- ls_req_i  in  1  load/store request.
- ls_we_i  in  1  1 = store.
- ls_addr_i  in  AW  load/store address.
- ls_wdata_i  in  DW  store data.
- ls_be_i  in  DW/8  byte enables.
- ls_gnt_o  out  1  load/store request accepted.
- ls_rvalid_o  out  1  load data valid, or store acknowledge.
- ls_rdata_o  out  DW  load data.
- mem_req_o  out  1  request to the shared memory port.
- mem_we_o  out  1  write enable.
- mem_addr_o  out  AW  address.
- mem_wdata_o  out  DW  write data.
- mem_be_o  out  DW/8  byte enables.
- mem_gnt_i  in  1  memory accepted the request.
- mem_rvalid_i  in  1  memory response; sent for reads and writes.
- mem_rdata_i  in  DW  response data.

Function
REQ-003 State machine SHALL have states IDLE, ISSUE, WAIT; at most one transaction outstanding.

REQ-004 IDLE, arbitration:
- Neither requester active: remain in IDLE.
- Otherwise select owner: LSU if ls_req_i=1 and starve_cnt<STARVE_MAX; else IF if if_req_i=1; else LSU.
- Latch owner's we/addr/wdata/be (IF: we=0, be=all ones, wdata=0).
- Next state ISSUE.

REQ-005 starve_cnt:
- Increment (saturating at STARVE_MAX) on each IDLE arbitration where if_req_i=1 and LSU wins.
- Clear to 0 when IF wins.
- Hold otherwise.

REQ-006 ISSUE:
- mem_req_o=1 and mem_* outputs driven from the latched fields, held stable until mem_gnt_i=1.
- In the mem_gnt_i cycle, owner's *_gnt_o=1 for exactly that cycle; next state WAIT.

REQ-007 WAIT:
- mem_req_o=0.
- On mem_rvalid_i=1, owner's *_rvalid_o=1 and *_rdata_o=mem_rdata_i in the same cycle (combinational pass-through); next state IDLE.

REQ-008 Non-owner rvalid/gnt SHALL be 0; *_rdata_o SHALL be 0 whenever its *_rvalid_o=0.

REQ-009 Out-of-state inputs SHALL be ignored with no state change: mem_gnt_i outside ISSUE; mem_rvalid_i outside WAIT, including mem_gnt_i and mem_rvalid_i both high in ISSUE.

REQ-010 Requesters SHALL hold req and fields until gnt; a request dropped before gnt SHALL still complete from the latched copy, and its response is delivered.

REQ-011 Minimum latency: request seen in IDLE at cycle N -> mem_req_o at N+1 -> gnt no earlier than N+1 -> rvalid no earlier than N+2; back-to-back throughput one transaction per 3 cycles minimum.

Reset
REQ-012 While srst_i=1:
- State=IDLE, starve_cnt=0, latched fields=0.
- All outputs 0 immediately (asynchronous), independent of sclk_i.

REQ-013 Reset asserted in ISSUE or WAIT SHALL abandon the transaction; a later mem_rvalid_i SHALL be ignored (state IDLE).

Verification
REQ-014 Bench SHALL cover these directed scenarios:
- IF read only: if_req_i=1, addr=0x100; gnt on 1st ISSUE cycle, mem_rdata_i=0xDEADBEEF -> if_gnt_o one pulse, if_rvalid_o=1 with if_rdata_o=0xDEADBEEF, mem_we_o=0, mem_be_o=0xF.
- LSU store: ls_we_i=1, addr=0x2000, wdata=0x12345678, be=0x3, mem_gnt_i delayed 3 cycles -> mem_* stable 4 ISSUE cycles, ls_gnt_o single pulse, ls_rvalid_o on ack, ls_rdata_o=0.
- Contention: both requesting continuously, STARVE_MAX=4 -> grant order LSU,LSU,LSU,LSU,IF, repeating; starve_cnt returns to 0 after the IF grant.
- Spurious inputs: mem_rvalid_i=1 in IDLE, mem_gnt_i=1 in WAIT -> no rvalid/gnt outputs, state unchanged.
- Reset mid-WAIT: srst_i pulsed in WAIT, then mem_rvalid_i=1 -> outputs 0 asynchronously, no rvalid delivered, next IF request served normally.
